// File: rtl/adder3_pipe.sv
// Pipelined multi-lane three-operand signed adder: a+b+c (+ previous d when
// accumulating) with per-sample saturate/wrap, two-cycle latency.
module adder3_pipe #(
  parameter int N  = 3,
  parameter int CH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [CH*(2**N)-1:0]  a,
  input  logic [CH*(2**N)-1:0]  b,
  input  logic [CH*(2**N)-1:0]  c,
  input  logic                  sat_en,
  input  logic                  acc_en,
  input  logic                  ovf_clr,
  output logic                  out_valid,
  output logic [CH*(2**N)-1:0]  d,
  output logic [CH-1:0]         ovf,
  output logic                  ovf_sticky
);

  localparam int W = 2**N;

  // The full sum fits W+2 bits; it is in range when its top three bits agree.
  function automatic logic sum_ovf(input logic [W+1:0] s);
    return !((s[W+1:W-1] == 3'b000) || (s[W+1:W-1] == 3'b111));
  endfunction

  function automatic logic [W-1:0] sum_clamp(input logic [W+1:0] s);
    logic [W-1:0] r;
    if (!sum_ovf(s)) begin
      r = s[W-1:0];
    end else if (s[W+1]) begin
      r = {1'b1, {(W-1){1'b0}}};
    end else begin
      r = {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction

  logic [CH-1:0][W:0]   p1_q, p1_d;
  logic [CH-1:0][W-1:0] c1_q, c1_d;
  logic                 sat1_q, sat1_d;
  logic                 acc1_q, acc1_d;
  logic                 v1_q, v1_d;
  logic [CH-1:0][W+1:0] sum_s;
  logic [CH-1:0][W-1:0] d_q, d_d;
  logic [CH-1:0]        ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sticky_q, sticky_d;

  // Stage 1: partial sum a+b and per-sample controls, captured only on in_valid.
  always_comb begin
    p1_d   = p1_q;
    c1_d   = c1_q;
    sat1_d = sat1_q;
    acc1_d = acc1_q;
    v1_d   = in_valid;
    if (in_valid) begin
      for (int k = 0; k < CH; k++) begin
        p1_d[k] = {a[k*W+W-1], a[k*W +: W]} + {b[k*W+W-1], b[k*W +: W]};
        c1_d[k] = c[k*W +: W];
      end
      sat1_d = sat_en;
      acc1_d = acc_en;
    end else begin
      p1_d   = p1_q;
      c1_d   = c1_q;
      sat1_d = sat1_q;
      acc1_d = acc1_q;
    end
  end

  // Stage 2: full sum with optional feedback of the registered result.
  always_comb begin
    sum_s = {(CH*(W+2)){1'b0}};
    for (int k = 0; k < CH; k++) begin
      sum_s[k] = {p1_q[k][W], p1_q[k]}
               + {{2{c1_q[k][W-1]}}, c1_q[k]}
               + (acc1_q ? {{2{d_q[k][W-1]}}, d_q[k]} : {(W+2){1'b0}});
    end
  end

  // Result, overflow and sticky flag; d/ovf hold through bubbles.
  always_comb begin
    d_d         = d_q;
    ovf_d       = ovf_q;
    out_valid_d = v1_q;
    if (v1_q) begin
      for (int k = 0; k < CH; k++) begin
        ovf_d[k] = sum_ovf(sum_s[k]);
        d_d[k]   = sat1_q ? sum_clamp(sum_s[k]) : sum_s[k][W-1:0];
      end
    end else begin
      d_d   = d_q;
      ovf_d = ovf_q;
    end
    sticky_d = (sticky_q & ~ovf_clr) | (v1_q & (|ovf_d));
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_q        <= {(CH*(W+1)){1'b0}};
      c1_q        <= {(CH*W){1'b0}};
      sat1_q      <= 1'b0;
      acc1_q      <= 1'b0;
      v1_q        <= 1'b0;
      d_q         <= {(CH*W){1'b0}};
      ovf_q       <= {CH{1'b0}};
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      p1_q        <= p1_d;
      c1_q        <= c1_d;
      sat1_q      <= sat1_d;
      acc1_q      <= acc1_d;
      v1_q        <= v1_d;
      d_q         <= d_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign d          = d_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_adder3_pipe.sv
// Self-checking bench for adder3_pipe: directed scenarios on an N=3/CH=2
// instance and a randomized stream on an N=4/CH=4 instance against an integer model.
module tb_adder3_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld3, sat3, acc3, clr3;
  logic [15:0] a3, b3, c3, d3;
  logic        ov3, st3;
  logic [1:0]  ovf3;
  logic        vld4, sat4, acc4, clr4;
  logic [63:0] a4, b4, c4, d4;
  logic        ov4, st4;
  logic [3:0]  ovf4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder3_pipe #(.N(3), .CH(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(vld3), .a(a3), .b(b3), .c(c3),
    .sat_en(sat3), .acc_en(acc3), .ovf_clr(clr3),
    .out_valid(ov3), .d(d3), .ovf(ovf3), .ovf_sticky(st3));

  adder3_pipe #(.N(4), .CH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(vld4), .a(a4), .b(b4), .c(c4),
    .sat_en(sat4), .acc_en(acc4), .ovf_clr(clr4),
    .out_valid(ov4), .d(d4), .ovf(ovf4), .ovf_sticky(st4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pk3(input int l0, input int l1);
    logic [7:0] x0, x1;
    x0 = l0[7:0];
    x1 = l1[7:0];
    return {x1, x0};
  endfunction

  function automatic int ln3(input logic [15:0] v, input int k);
    logic signed [7:0] t;
    t = v[k*8 +: 8];
    return int'(t);
  endfunction

  function automatic int ln4(input logic [63:0] v, input int k);
    logic signed [15:0] t;
    t = v[k*16 +: 16];
    return int'(t);
  endfunction

  // Reference: exact integer sum mapped to W-bit signed by clamping or modulo.
  function automatic void ref_sum(input int w, input int s, input bit sat,
                                  output int dv, output bit ov);
    int mx, mn, m;
    mx = (1 << (w-1)) - 1;
    mn = -(1 << (w-1));
    m  = 1 << w;
    ov = (s > mx) || (s < mn);
    if (sat) begin
      dv = (s > mx) ? mx : ((s < mn) ? mn : s);
    end else begin
      dv = ((s % m) + m) % m;
      if (dv > mx) dv = dv - m;
    end
  endfunction

  // One sample on the small instance, then one idle cycle: result visible afterwards.
  task automatic send3(input int a0, input int b0, input int c0, input logic s, input logic acc);
    a3 = pk3(a0, a0); b3 = pk3(b0, b0); c3 = pk3(c0, c0);
    sat3 = s; acc3 = acc; vld3 = 1'b1;
    step();
    vld3 = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld3 = 1'b1; a3 = 16'($urandom()); b3 = 16'($urandom()); c3 = 16'($urandom());
      vld4 = 1'b1; a4 = {$urandom(), $urandom()}; b4 = {$urandom(), $urandom()};
      c4 = {$urandom(), $urandom()};
      step();
      n_checks++;
      if ({ov3, d3, ovf3, st3} !== 20'd0) begin
        n_fail++; $display("FAIL reset3: got ov=%0b d=%h ovf=%b st=%0b, want all 0", ov3, d3, ovf3, st3);
      end
      n_checks++;
      if ({ov4, d4, ovf4, st4} !== 70'd0) begin
        n_fail++; $display("FAIL reset4: got ov=%0b d=%h ovf=%b st=%0b, want all 0", ov4, d4, ovf4, st4);
      end
    end
    rst = 1'b1; vld3 = 1'b0; vld4 = 1'b0;
    a4 = 64'd0; b4 = 64'd0; c4 = 64'd0;
    step();
    n_checks++;
    if ({ov3, d3, ovf3, st3} !== 20'd0) begin
      n_fail++; $display("FAIL reset_release: got ov=%0b d=%h ovf=%b st=%0b, want all 0", ov3, d3, ovf3, st3);
    end
  endtask

  task automatic test_basic();
    a3 = pk3(5, -4); b3 = pk3(12, -6); c3 = pk3(3, 1);
    sat3 = 1'b0; acc3 = 1'b0; vld3 = 1'b1;
    step();
    vld3 = 1'b0;
    n_checks++;
    if (ov3 !== 1'b0) begin
      n_fail++; $display("FAIL basic_early: out_valid=%0b after 1 cycle, want 0", ov3);
    end
    step();
    n_checks++;
    if (ov3 !== 1'b1 || ln3(d3, 0) != 20 || ln3(d3, 1) != -9 || ovf3 !== 2'b00) begin
      n_fail++; $display("FAIL basic: ov=%0b d0=%0d d1=%0d ovf=%b, want 1 20 -9 00",
                         ov3, ln3(d3, 0), ln3(d3, 1), ovf3);
    end
    step();
    n_checks++;
    if (ov3 !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse: out_valid=%0b on 2nd cycle, want 0", ov3);
    end
  endtask

  task automatic test_overflow();
    send3(100, 100, 100, 1'b1, 1'b0);
    n_checks++;
    if (ln3(d3, 0) != 127 || ln3(d3, 1) != 127 || ovf3 !== 2'b11 || st3 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sat_pos: d0=%0d d1=%0d ovf=%b st=%0b, want 127 127 11 1",
                         ln3(d3, 0), ln3(d3, 1), ovf3, st3);
    end
    send3(100, 100, 100, 1'b0, 1'b0);
    n_checks++;
    if (ln3(d3, 0) != 44 || ln3(d3, 1) != 44 || ovf3 !== 2'b11) begin
      n_fail++; $display("FAIL ovf_wrap: d0=%0d d1=%0d ovf=%b, want 44 44 11", ln3(d3, 0), ln3(d3, 1), ovf3);
    end
    send3(-128, -128, -128, 1'b1, 1'b0);
    n_checks++;
    if (ln3(d3, 0) != -128 || ln3(d3, 1) != -128 || ovf3 !== 2'b11) begin
      n_fail++; $display("FAIL ovf_sat_neg: d0=%0d d1=%0d ovf=%b, want -128 -128 11", ln3(d3, 0), ln3(d3, 1), ovf3);
    end
    clr3 = 1'b1;
    step();
    clr3 = 1'b0;
    n_checks++;
    if (st3 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr: sticky=%0b, want 0", st3);
    end
    a3 = pk3(100, 100); b3 = a3; c3 = a3; sat3 = 1'b1; acc3 = 1'b0; vld3 = 1'b1;
    step();
    vld3 = 1'b0; clr3 = 1'b1;
    step();
    clr3 = 1'b0;
    n_checks++;
    if (st3 !== 1'b1 || ov3 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set_wins: sticky=%0b ov=%0b, want 1 1", st3, ov3);
    end
  endtask

  task automatic test_accumulate();
    a3 = pk3(1, 1); b3 = a3; c3 = a3; sat3 = 1'b0; acc3 = 1'b0; vld3 = 1'b1;
    step();
    acc3 = 1'b1;
    step();
    n_checks++;
    if (ov3 !== 1'b1 || d3 !== pk3(3, 3)) begin
      n_fail++; $display("FAIL acc_first: ov=%0b d=%h, want 1 %h", ov3, d3, pk3(3, 3));
    end
    step();
    vld3 = 1'b0;
    n_checks++;
    if (ov3 !== 1'b1 || d3 !== pk3(6, 6)) begin
      n_fail++; $display("FAIL acc_second: ov=%0b d=%h, want 1 %h", ov3, d3, pk3(6, 6));
    end
    step();
    n_checks++;
    if (ov3 !== 1'b1 || d3 !== pk3(9, 9)) begin
      n_fail++; $display("FAIL acc_third: ov=%0b d=%h, want 1 %h", ov3, d3, pk3(9, 9));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (ov3 !== 1'b0 || d3 !== pk3(9, 9)) begin
        n_fail++; $display("FAIL acc_bubble%0d: ov=%0b d=%h, want 0 %h", i, ov3, d3, pk3(9, 9));
      end
    end
    send3(1, 1, 1, 1'b0, 1'b1);
    n_checks++;
    if (d3 !== pk3(12, 12)) begin
      n_fail++; $display("FAIL acc_after_gap: d=%h, want %h", d3, pk3(12, 12));
    end
    send3(3, 3, 3, 1'b0, 1'b0);
    a3 = pk3(120, 120); b3 = 16'd0; c3 = 16'd0; sat3 = 1'b1; acc3 = 1'b1; vld3 = 1'b1;
    step();
    vld3 = 1'b0;
    step();
    n_checks++;
    if (d3 !== pk3(127, 127) || ovf3 !== 2'b11) begin
      n_fail++; $display("FAIL acc_sat: d=%h ovf=%b, want %h 11", d3, ovf3, pk3(127, 127));
    end
  endtask

  task automatic test_streaming();
    int    prev [4];
    logic [63:0] exp_d [64];
    logic [3:0]  exp_o [64];
    int    s, dv;
    bit    ov;
    for (int k = 0; k < 4; k++) prev[k] = 0;
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) begin
        vld4 = 1'b1;
        sat4 = 1'($urandom_range(0, 1));
        acc4 = 1'($urandom_range(0, 1));
        a4 = {$urandom(), $urandom()}; b4 = {$urandom(), $urandom()}; c4 = {$urandom(), $urandom()};
        for (int k = 0; k < 4; k++) begin
          s = ln4(a4, k) + ln4(b4, k) + ln4(c4, k) + (acc4 ? prev[k] : 0);
          ref_sum(16, s, sat4, dv, ov);
          prev[k] = dv;
          exp_d[i][k*16 +: 16] = dv[15:0];
          exp_o[i][k] = ov;
        end
      end else begin
        vld4 = 1'b0;
      end
      step();
      n_checks++;
      if (i == 0) begin
        if (ov4 !== 1'b0) begin
          n_fail++; $display("FAIL stream_early: out_valid=%0b, want 0", ov4);
        end
      end else if (ov4 !== 1'b1 || d4 !== exp_d[i-1] || ovf4 !== exp_o[i-1]) begin
        n_fail++; $display("FAIL stream[%0d]: ov=%0b d=%h ovf=%b, want 1 %h %b",
                           i-1, ov4, d4, ovf4, exp_d[i-1], exp_o[i-1]);
      end
    end
    step();
    n_checks++;
    if (ov4 !== 1'b0 || d4 !== exp_d[63]) begin
      n_fail++; $display("FAIL stream_end: ov=%0b d=%h, want 0 %h", ov4, d4, exp_d[63]);
    end
  endtask

  task automatic test_reset_midstream();
    a3 = pk3(7, -7); b3 = a3; c3 = a3; sat3 = 1'b0; acc3 = 1'b0; vld3 = 1'b1;
    step();
    a3 = pk3(11, 22); rst = 1'b0;
    step();
    n_checks++;
    if (ov3 !== 1'b0 || d3 !== 16'd0 || st3 !== 1'b0) begin
      n_fail++; $display("FAIL midreset: ov=%0b d=%h st=%0b, want 0 0000 0", ov3, d3, st3);
    end
    rst = 1'b1; vld3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (ov3 !== 1'b0) begin
        n_fail++; $display("FAIL midreset_flush%0d: out_valid=%0b, want 0", i, ov3);
      end
    end
    send3(1, 1, 1, 1'b0, 1'b1);
    n_checks++;
    if (d3 !== pk3(3, 3)) begin
      n_fail++; $display("FAIL midreset_acc: d=%h, want %h", d3, pk3(3, 3));
    end
  endtask

  initial begin
    rst = 1'b0;
    vld3 = 1'b0; sat3 = 1'b0; acc3 = 1'b0; clr3 = 1'b0;
    a3 = 16'd0; b3 = 16'd0; c3 = 16'd0;
    vld4 = 1'b0; sat4 = 1'b0; acc4 = 1'b0; clr4 = 1'b0;
    a4 = 64'd0; b4 = 64'd0; c4 = 64'd0;
    test_reset();
    test_basic();
    test_overflow();
    test_accumulate();
    test_streaming();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder3_pipe.md
# adder3_pipe

Parametrised, pipelined three-operand signed adder for the FFT datapath. Sums CH independent lanes of `a + b + c` at full throughput with a valid strobe and fixed two-cycle latency. Each sample selects saturating or wrapping output, and can optionally accumulate onto the lane's previous result. It replaces the single-lane, fixed-width combinational adder in butterfly and twiddle-sum paths.

## Interface
Parameters:
- `N`, 3, log2 of lane width; lane width W = 2**N bits.
- `CH`, 2, number of independent lanes.

Ports:
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input sample present this cycle.
- `a`, `b`, `c`  in  CH*W each  packed signed two's-complement operands; lane k at bits [k*W +: W].
- `sat_en`  in  1  1 = saturate, 0 = wrap. Sampled with `in_valid`.
- `acc_en`  in  1  1 = add the lane's current `d` into the sum. Sampled with `in_valid`.
- `ovf_clr`  in  1  clears `ovf_sticky`.
- `out_valid`  out  1  `d`/`ovf` hold a new result.
- `d`  out  CH*W  packed signed results.
- `ovf`  out  CH  per-lane overflow of the current result.
- `ovf_sticky`  out  1  OR of all `ovf` since last clear.

## Operation
- Stage 1, loads only when `in_valid`=1:
  - p1[k] = a[k] + b[k], sign-extended to W+1 bits.
  - Registers c[k], `sat_en`, `acc_en`.
  - v1 <= `in_valid` every cycle.
- Stage 2, loads only when v1=1:
  - Full sum s[k] = p1[k] + c1[k] + (acc_en1 ? d[k] : 0), sign-extended to W+2 bits.
  - Range R = [-2^(W-1), 2^(W-1)-1].
  - ovf[k] <= (s[k] outside R).
  - d[k] <= sat_en1 ? clamp(s[k], R) : s[k][W-1:0].
  - out_valid <= v1 every cycle.
- Bubbles (v1=0): `d` and `ovf` hold their values so accumulation spans gaps. `out_valid` = 0.
- Accumulation feeds back the registered `d`. Back-to-back accumulating samples chain with no stall.
- `ovf_sticky` <= (ovf_sticky & ~ovf_clr) | (v1 & |ovf_next). Set wins over a simultaneous clear.
- Reset (`rst`=0 at an edge) clears all registers: v1, out_valid, d, ovf, ovf_sticky, and stage-1 data all go to 0. In-flight samples are discarded and never produce `out_valid`.

## Timing
- Latency: a sample accepted at edge T (`in_valid`=1 before edge T) appears with `out_valid`=1 after edge T+1, i.e. 2 cycles.
- Throughput: one sample per cycle per lane, no backpressure. The input is always accepted.
- Reset values: `out_valid`=0, `d`=0, `ovf`=0, `ovf_sticky`=0.
- `rst` is deasserted at edge R. A valid sample presented at edge R+1 emerges at R+2; there is no warm-up.
- `sat_en` and `acc_en` are per-sample. Changing them between back-to-back samples affects only the sample they accompany.
- `ovf_clr` takes effect at the next edge, independent of `in_valid`.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `in_valid`=1 and random data -> `out_valid`=0, `d`=0, `ovf`=0, `ovf_sticky`=0 throughout, and 0 for the first cycle after release.
- **Basic (N=3, CH=2):**
  - Stimulus: one valid cycle; lane0 a=5, b=12, c=3; lane1 a=-4, b=-6, c=1; sat_en=0, acc_en=0.
  - Response: exactly 2 cycles later `out_valid`=1 for one cycle; d lane0=20, lane1=-9; ovf=0.
- **Overflow modes:**
  - a=b=c=100, sat_en=1 -> d=127, ovf=1, ovf_sticky=1.
  - Same with sat_en=0 -> d=44 (300 mod 256), ovf=1.
  - a=b=c=-128 with sat_en=1 -> d=-128, ovf=1.
  - Pulse ovf_clr with no overflow -> ovf_sticky=0.
  - ovf_clr coincident with a new overflow -> ovf_sticky stays 1.
- **Accumulate:**
  - Back-to-back samples with a=b=c=1 and acc_en=0,1,1 -> d=3,6,9 on consecutive cycles.
  - Then a 3-cycle bubble, then acc_en=1 -> d=12; `d` holds 9 during the bubble.
  - acc_en=1 with a=120, b=c=0 after d=9, sat_en=1 -> d=127, ovf=1.
- **Streaming:**
  - 64 back-to-back random vectors with random sat_en/acc_en, CH=4, N=4, against a reference model.
  - `out_valid` high for 64 consecutive cycles starting at latency 2; every `d` and `ovf` matches.
- **Reset mid-stream:**
  - Drive `rst`=0 for one cycle while 2 samples are in flight -> neither produces `out_valid`; d=0 after that edge.
  - The next sample, acc_en=1 with a=b=c=1, yields d=3.
